wb_commit_stage: RTL and testbench
==================================

Name: wb_commit_stage

Overview:
- Parametrised writeback/commit stage for the pipelined RV32I core; successor to the single-register WB stage.
- Accepts retiring instructions from MEM with a valid/allow_in handshake and buffers them in a DEPTH-entry in-order commit queue.
- Drains the queue to the register-file write port under an rf_ready grant; the port may be stolen by the CSR/trap unit.
- Retires excepting instructions without a write, pulses trap, and optionally counts retired instructions (minstret source).

Parameters:
XLEN, 32, data width of the writeback value
REG_AW, 5, register address width
DEPTH, 2, commit queue entries; power of two, at least 2
CNT_W, $clog2(DEPTH+1), occupancy counter width (derived, not overridable)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
in_valid  in  1  MEM has an instruction for WB
in_rf_we  in  1  instruction writes rd
in_rd  in  REG_AW  destination register
in_data  in  XLEN  writeback value
in_exc  in  1  instruction raised an exception in an earlier stage
allow_in  out  1  WB can accept this cycle
rf_ready  in  1  register-file write port granted to WB this cycle
rf_we  out  1  register-file write enable
rf_waddr  out  REG_AW  register-file write address
rf_wdata  out  XLEN  register-file write data
head_valid  out  1  queue head is occupied; also the ID forwarding valid
trap  out  1  one-cycle pulse when an excepting entry retires
occupancy  out  CNT_W  current queue entry count
instret  out  64  retired-instruction count (only with WB_INSTRET_EN)

Behaviour:
- Reset (rst_n low at a clk edge): rd/wr pointers 0, occupancy 0, head_valid 0, rf_we 0, trap 0, instret 0. Queue data RAM is not reset. Reset mid-drain discards all entries; no write is issued in the reset cycle.
- allow_in = (occupancy != DEPTH). It is purely registered-state derived, with no combinational path from rf_ready.
- Push: in_valid && allow_in at a clk edge writes {in_rf_we && (in_rd != 0), in_rd, in_data, in_exc} at wr_ptr, then wr_ptr+1 mod DEPTH.
- Head entry fields: h_we, h_rd, h_data, h_exc.
- pop = head_valid && (h_exc || !h_we || rf_ready).
- rf_we = head_valid && h_we && !h_exc && rf_ready. rf_waddr = h_rd, rf_wdata = h_data; both are don't-care when rf_we is 0.
- trap = head_valid && h_exc (combinational, aligned with pop). Since h_exc entries pop unconditionally, trap is high for exactly one cycle per excepting entry.
- On pop, rd_ptr advances.
- Occupancy:
  - push only: +1
  - pop only: −1
  - push and pop in the same cycle: unchanged
- Pointer wrap: natural modulo DEPTH. Full (occupancy == DEPTH) and empty (occupancy == 0) are distinguished only by occupancy.
- Latency: an accepted instruction into an empty queue with rf_ready high is written one cycle after acceptance, matching the existing one-register WB timing. Throughput is 1 per cycle while rf_ready stays high.
- Stall: with rf_ready low, head entries with h_we && !h_exc hold indefinitely. Entries behind the head do not bypass it; the queue is strictly in-order.
- Full with a simultaneous pop: allow_in stays 0 that cycle (conservative). It rises the cycle after.
- rd == 0: stored with h_we = 0 and popped without a write. It still counts as retired.

Optional Feature:
- Macro: WB_INSTRET_EN.
- Defined:
  - 64-bit instret register, reset 0.
  - Increments by 1 on every pop with !h_exc.
  - Wraps 2^64−1 → 0.
- Undefined:
  - instret port and counter absent; no other behavioural change.

Decomposition:
- Shared defines file: the WB entry field layout/width constant (1+REG_AW+XLEN+1). This sits alongside the existing pipeline bus-width constants.
- One sub-module, wb_commit_fifo: the DEPTH-entry storage, pointers and occupancy, with push/pop/full/empty interface.
- wb_commit_stage itself holds pop/grant logic, trap and instret.

Test Plan:
- Reset then a single push {we=1, rd=5, data=0xDEADBEEF}, rf_ready=1 → rf_we=1, waddr=5, wdata=0xDEADBEEF exactly one cycle after accept; occupancy back to 0.
- rf_ready=0 while pushing 3 writes with DEPTH=2 → allow_in drops after the 2nd accept; 3rd input held. Raise rf_ready → writes rd in order 1,2,3 on consecutive cycles.
- Push an entry with exc=1, rd=7 → trap high one cycle, rf_we stays 0, instret unchanged (macro on).
- Push we=1, rd=0, data=0x1234 with rf_ready=0 → pops without waiting, rf_we never asserts, instret +1.
- Back-to-back 100 pushes with rf_ready=1 → 100 writes at 1/cycle, allow_in constant 1, instret=100.
- Assert rst_n=0 with occupancy=2 and rf_ready=0 → next cycle occupancy=0, head_valid=0, no writes issued after reset release.

Source files
------------

// File: rtl/wb_commit_stage_pkg.sv
// rtl/wb_commit_stage_pkg.sv - WB commit entry layout shared with the pipeline bus-width constants.
package wb_commit_stage_pkg;

    localparam int WB_XLEN   = 32;
    localparam int WB_REG_AW = 5;

    // Entry layout, MSB first: {we, rd, data, exc}
    function automatic int wb_entry_w(input int reg_aw, input int xlen);
        return 1 + reg_aw + xlen + 1;
    endfunction

    localparam int WB_ENTRY_W = 1 + WB_REG_AW + WB_XLEN + 1;

endpackage

// File: rtl/wb_commit_fifo.sv
// rtl/wb_commit_fifo.sv - DEPTH-entry in-order commit queue; full/empty are told apart by count only.
module wb_commit_fifo
    import wb_commit_stage_pkg::*;
#(
    parameter int W     = WB_ENTRY_W,
    parameter int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [W-1:0]     push_data,
    input  logic             pop,
    output logic [W-1:0]     head_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately left out of reset; count alone says what is live.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head_data = mem_q[rd_ptr_q];
    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;

endmodule

// File: rtl/wb_commit_stage.sv
// rtl/wb_commit_stage.sv - RV32I writeback/commit stage draining a commit queue to the RF port.
// Optional retired-instruction counter enabled by WB_INSTRET_EN.
module wb_commit_stage
    import wb_commit_stage_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int DEPTH  = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              in_rf_we,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [XLEN-1:0]   in_data,
    input  logic              in_exc,
    output logic              allow_in,
    input  logic              rf_ready,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [XLEN-1:0]   rf_wdata,
    output logic              head_valid,
    output logic              trap,
    output logic [CNT_W-1:0]  occupancy
`ifdef WB_INSTRET_EN
    ,
    output logic [63:0]       instret
`endif
);

    localparam int ENTRY_W = wb_entry_w(REG_AW, XLEN);

    logic               push, pop, full, empty;
    logic [ENTRY_W-1:0] push_data, head_data;
    logic               h_we, h_exc;
    logic [REG_AW-1:0]  h_rd;
    logic [XLEN-1:0]    h_data;

    // Writes to x0 are folded into a non-writing entry at the door.
    assign push_data = {in_rf_we && (in_rd != '0), in_rd, in_data, in_exc};
    assign push      = in_valid && allow_in;

    wb_commit_fifo #(
        .W     (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head_data (head_data),
        .full      (full),
        .empty     (empty),
        .count     (occupancy)
    );

    assign h_we   = head_data[ENTRY_W-1];
    assign h_rd   = head_data[ENTRY_W-2 -: REG_AW];
    assign h_data = head_data[XLEN:1];
    assign h_exc  = head_data[0];

    assign allow_in   = !full;
    assign head_valid = !empty;
    assign pop        = head_valid && (h_exc || !h_we || rf_ready);

    // Gated by rst_n so a reset landing mid-drain never leaks a write or trap.
    assign rf_we    = rst_n && head_valid && h_we && !h_exc && rf_ready;
    assign rf_waddr = h_rd;
    assign rf_wdata = h_data;
    assign trap     = rst_n && head_valid && h_exc;

`ifdef WB_INSTRET_EN
    logic [63:0] instret_q, instret_d;

    always_comb begin
        instret_d = instret_q + 64'(pop && !h_exc);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instret_q <= '0;
        end else begin
            instret_q <= instret_d;
        end
    end

    assign instret = instret_q;
`endif

endmodule

// File: tb/tb_wb_commit_stage.sv
// tb/tb_wb_commit_stage.sv - directed and random checks of wb_commit_stage against a queue model.
module tb_wb_commit_stage;

    localparam int DEPTH = 2;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid, in_rf_we, in_exc, rf_ready;
    logic [4:0]       in_rd;
    logic [31:0]      in_data;
    logic             allow_in, rf_we, head_valid, trap;
    logic [4:0]       rf_waddr;
    logic [31:0]      rf_wdata;
    logic [CNT_W-1:0] occupancy;
`ifdef WB_INSTRET_EN
    logic [63:0]      instret;
`endif

    always #5 clk = ~clk;

    wb_commit_stage #(.XLEN(32), .REG_AW(5), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_rf_we   (in_rf_we),
        .in_rd      (in_rd),
        .in_data    (in_data),
        .in_exc     (in_exc),
        .allow_in   (allow_in),
        .rf_ready   (rf_ready),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .head_valid (head_valid),
        .trap       (trap),
        .occupancy  (occupancy)
`ifdef WB_INSTRET_EN
        ,
        .instret    (instret)
`endif
    );

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        exc;
    } ent_t;

    ent_t        mq[$];
    logic [4:0]  wlog[$];
    logic [63:0] m_instret;
    int          total = 0;
    int          bad   = 0;
    int          traps = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drv(input bit v, input bit we, input logic [4:0] rd,
                       input logic [31:0] d, input bit exc, input bit rdy);
        in_valid = v;
        in_rf_we = we;
        in_rd    = rd;
        in_data  = d;
        in_exc   = exc;
        rf_ready = rdy;
    endtask

    // Called at a negedge with inputs already driven; checks, advances the model, moves one cycle.
    task automatic cycle();
        ent_t h;
        bit   hv, exp_we, pop, push;
        h = '{we: 1'b0, rd: 5'd0, data: 32'd0, exc: 1'b0};
        #1;
        hv = (mq.size() > 0);
        if (hv) h = mq[0];
        exp_we = rst_n && hv && h.we && !h.exc && rf_ready;
        chk("head_valid", 64'(head_valid), 64'(hv));
        chk("occupancy", 64'(occupancy), 64'(mq.size()));
        chk("allow_in", 64'(allow_in), 64'(mq.size() != DEPTH));
        chk("rf_we", 64'(rf_we), 64'(exp_we));
        chk("trap", 64'(trap), 64'(rst_n && hv && h.exc));
        if (exp_we) begin
            chk("rf_waddr", 64'(rf_waddr), 64'(h.rd));
            chk("rf_wdata", 64'(rf_wdata), 64'(h.data));
        end
`ifdef WB_INSTRET_EN
        chk("instret", instret, m_instret);
`endif
        if (rf_we === 1'b1) wlog.push_back(rf_waddr);
        if (trap === 1'b1) traps++;
        pop  = hv && (h.exc || !h.we || rf_ready);
        push = in_valid && (mq.size() != DEPTH);
        if (!rst_n) begin
            mq.delete();
            m_instret = 64'd0;
        end else begin
            if (pop) begin
                if (!h.exc) m_instret = m_instret + 64'd1;
                void'(mq.pop_front());
            end
            if (push) mq.push_back('{we: in_rf_we && (in_rd != 5'd0), rd: in_rd, data: in_data, exc: in_exc});
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int exp_order[3];
`ifdef WB_INSTRET_EN
        logic [63:0] i0;
`endif
        exp_order = '{1, 2, 3};
        m_instret = 64'd0;
        rst_n = 1'b0;
        drv(0, 0, 5'd0, 32'd0, 0, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cycle();

        // Single write, one cycle after accept
        wlog.delete();
        drv(1, 1, 5'd5, 32'hDEADBEEF, 0, 1);
        cycle();
        drv(0, 0, 5'd0, 32'd0, 0, 1);
        cycle();
        cycle();
        chk("t1_wr_count", 64'(wlog.size()), 64'd1);
        if (wlog.size() > 0) chk("t1_wr_addr", 64'(wlog[0]), 64'd5);

        // Fill under stall, then drain in order
        wlog.delete();
        drv(1, 1, 5'd1, 32'h11, 0, 0);
        cycle();
        drv(1, 1, 5'd2, 32'h22, 0, 0);
        cycle();
        drv(1, 1, 5'd3, 32'h33, 0, 0);
        cycle();
        chk("t2_allow_low", 64'(allow_in), 64'd0);
        cycle();
        drv(1, 1, 5'd3, 32'h33, 0, 1);
        cycle();
        cycle();
        drv(0, 0, 5'd0, 32'd0, 0, 1);
        cycle();
        cycle();
        chk("t2_wr_count", 64'(wlog.size()), 64'd3);
        for (int i = 0; i < 3 && i < wlog.size(); i++)
            chk("t2_wr_order", 64'(wlog[i]), 64'(exp_order[i]));

        // Excepting entry
        wlog.delete();
        traps = 0;
        drv(1, 1, 5'd7, 32'h77, 1, 1);
        cycle();
        drv(0, 0, 5'd0, 32'd0, 0, 1);
        cycle();
        cycle();
        chk("t3_traps", 64'(traps), 64'd1);
        chk("t3_no_write", 64'(wlog.size()), 64'd0);

        // rd==0 retires without waiting for the port
        wlog.delete();
        drv(1, 1, 5'd0, 32'h1234, 0, 0);
        cycle();
        drv(0, 0, 5'd0, 32'd0, 0, 0);
        cycle();
        cycle();
        chk("t4_no_write", 64'(wlog.size()), 64'd0);
        chk("t4_empty", 64'(occupancy), 64'd0);

        // Back-to-back stream
        wlog.delete();
`ifdef WB_INSTRET_EN
        i0 = instret;
`endif
        repeat (100) begin
            drv(1, 1, 5'($urandom_range(1, 31)), $urandom, 0, 1);
            cycle();
        end
        drv(0, 0, 5'd0, 32'd0, 0, 1);
        cycle();
        cycle();
        chk("t5_wr_count", 64'(wlog.size()), 64'd100);
`ifdef WB_INSTRET_EN
        chk("t5_instret_delta", instret - i0, 64'd100);
`endif

        // Reset while full and stalled
        drv(1, 1, 5'd9, 32'h99, 0, 0);
        cycle();
        drv(1, 1, 5'd10, 32'hAA, 0, 0);
        cycle();
        chk("t6_full", 64'(occupancy), 64'd2);
        drv(0, 0, 5'd0, 32'd0, 0, 0);
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        chk("t6_occ_after_rst", 64'(occupancy), 64'd0);
        chk("t6_hv_after_rst", 64'(head_valid), 64'd0);
        wlog.delete();
        drv(0, 0, 5'd0, 32'd0, 0, 1);
        repeat (3) cycle();
        chk("t6_no_write", 64'(wlog.size()), 64'd0);

        // Random traffic
        repeat (400) begin
            rst_n = ($urandom_range(0, 99) != 0);
            drv($urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0,
                5'($urandom_range(0, 31)), $urandom,
                $urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0);
            cycle();
        end
        rst_n = 1'b1;
        drv(0, 0, 5'd0, 32'd0, 0, 1);
        repeat (4) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
